// File: rtl/apb_pkg.sv
// Shared types and helpers for the round-robin APB master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Bits needed to count 0..v-1; never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            vld
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NREQ single-transfer requesters onto one APB bus,
// honours pready wait states and aborts a transfer after TIMEOUT unready ACCESS cycles.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  done,
  output logic [DW-1:0]    rdata,
  output logic             err,
  output logic [AW-1:0]    paddr,
  output logic [DW-1:0]    pwdata,
  output logic             pwrite,
  output logic             psel,
  output logic             penable,
  input  logic [DW-1:0]    prdata,
  input  logic             pready,
  input  logic             pslverr
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(TIMEOUT);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;

  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_write;

  // The requester being acknowledged this cycle is still holding req; keep it out.
  assign elig = req & ~done;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (elig),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        sel_addr  = sel_addr  | req_addr[i*AW +: AW];
        sel_wdata = sel_wdata | req_wdata[i*DW +: DW];
        sel_write = sel_write | req_write[i];
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      cnt     <= '0;
      done    <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pwrite  <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
    end else begin
      done  <= '0;
      rdata <= '0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            win    <= pick_idx;
            paddr  <= sel_addr;
            pwrite <= sel_write;
            pwdata <= sel_write ? sel_wdata : '0;
            psel   <= 1'b1;
            ptr    <= (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            done    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            rdata   <= pwrite ? '0 : prdata;
            err     <= pslverr;
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= IDLE;
          end else if (cnt == CW'(TIMEOUT-1)) begin
            // Watchdog abort: the slave never answered.
            done    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            err     <= 1'b1;
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: arbitration, waits, timeout, slave error, reset.
module tb_apb_rr_master;

  localparam int NREQ = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  logic              hclk = 1'b0;
  logic              hreset;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   done;
  logic [DW-1:0]     rdata;
  logic              err;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [DW-1:0]     prdata;
  logic              pready;
  logic              pslverr;

  int checks = 0;
  int failures = 0;

  apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .hclk(hclk), .hreset(hreset), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata),
    .err(err), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel),
    .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 hclk = ~hclk;

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (done == '0 && n < maxc);
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
  endtask

  task automatic test_reset;
    hreset = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    checks++; if ({psel, penable, pwrite, err} !== 4'b0) begin failures++; $display("FAIL reset_ctl: got %b required 0000", {psel, penable, pwrite, err}); end
    checks++; if (done !== 4'b0) begin failures++; $display("FAIL reset_done: got %b required 0000", done); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h required 0", rdata); end
    checks++; if (paddr !== 32'h0) begin failures++; $display("FAIL reset_paddr: got %h required 0", paddr); end
    checks++; if (pwdata !== 32'h0) begin failures++; $display("FAIL reset_pwdata: got %h required 0", pwdata); end
    hreset = 1'b0;
  endtask

  task automatic test_single_read;
    set_req(2, 1'b0, 32'h40, 32'h99999999);
    prdata = 32'hDEADBEEF; pready = 1'b1;
    tick();
    checks++; if ({psel, penable, pwrite} !== 3'b100) begin failures++; $display("FAIL rd_setup: got %b required 100", {psel, penable, pwrite}); end
    checks++; if (paddr !== 32'h40) begin failures++; $display("FAIL rd_paddr: got %h required 40", paddr); end
    checks++; if (pwdata !== 32'h0) begin failures++; $display("FAIL rd_pwdata: got %h required 0", pwdata); end
    tick();
    checks++; if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL rd_access: got %b required 11", {psel, penable}); end
    tick();
    checks++; if (done !== 4'b0100) begin failures++; $display("FAIL rd_done: got %b required 0100", done); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_rdata: got %h required deadbeef", rdata); end
    checks++; if ({err, psel, penable} !== 3'b000) begin failures++; $display("FAIL rd_end: got %b required 000", {err, psel, penable}); end
    req = '0;
    tick();
    checks++; if ({done, rdata} !== 36'h0) begin failures++; $display("FAIL rd_pulse: got %b/%h required 0/0", done, rdata); end
  endtask

  task automatic test_write_wait;
    set_req(0, 1'b1, 32'h10, 32'hA5A5A5A5);
    pready = 1'b0; prdata = 32'h77777777;
    tick();
    checks++; if ({psel, pwrite, paddr, pwdata} !== {1'b1, 1'b1, 32'h10, 32'hA5A5A5A5}) begin failures++; $display("FAIL wr_grant: got %b %b %h %h required 1 1 10 a5a5a5a5", psel, pwrite, paddr, pwdata); end
    tick();
    for (int w = 0; w < 3; w++) begin
      tick();
      checks++; if ({done, penable, paddr, pwdata} !== {4'b0, 1'b1, 32'h10, 32'hA5A5A5A5}) begin failures++; $display("FAIL wr_wait%0d: got %b %b %h %h required 0000 1 10 a5a5a5a5", w, done, penable, paddr, pwdata); end
    end
    pready = 1'b1;
    tick();
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL wr_done: got %b required 0001", done); end
    checks++; if ({rdata, err} !== 33'h0) begin failures++; $display("FAIL wr_rdata: got %h err %b required 0 0", rdata, err); end
    req = '0;
  endtask

  task automatic test_round_robin;
    int order[6];
    int cyc[6];
    int k;
    int c;
    hreset = 1'b1; tick(); hreset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(32'h100 + i * 4), 32'h0);
    prdata = 32'h12345678; pready = 1'b1;
    k = 0; c = 0;
    while (k < 6 && c < 60) begin
      tick(); c++;
      if (done != '0) begin
        order[k] = -1;
        for (int b = 0; b < NREQ; b++) if (done[b]) order[k] = b;
        cyc[k] = c;
        checks++; if (rdata !== 32'h12345678) begin failures++; $display("FAIL rr_rdata%0d: got %h required 12345678", k, rdata); end
        k++;
      end
    end
    req = '0;
    checks++; if (k != 6) begin failures++; $display("FAIL rr_count: got %0d required 6", k); end
    checks++; if (k > 0 && cyc[0] != 3) begin failures++; $display("FAIL rr_first: got %0d required 3", cyc[0]); end
    for (int j = 0; j < k; j++) begin
      checks++; if (order[j] != j % NREQ) begin failures++; $display("FAIL rr_order%0d: got %0d required %0d", j, order[j], j % NREQ); end
      if (j > 0) begin
        checks++; if (cyc[j] - cyc[j-1] != 3) begin failures++; $display("FAIL rr_gap%0d: got %0d required 3", j, cyc[j] - cyc[j-1]); end
      end
    end
  endtask

  task automatic test_pointer_wrap;
    int n;
    int order[2];
    int k;
    int c;
    set_req(2, 1'b0, 32'h200, 32'h0);
    wait_done(10, n);
    checks++; if (done !== 4'b0100) begin failures++; $display("FAIL wrap_prep: got %b required 0100", done); end
    req = '0;
    set_req(0, 1'b0, 32'h300, 32'h0);
    set_req(1, 1'b0, 32'h304, 32'h0);
    k = 0; c = 0;
    while (k < 2 && c < 20) begin
      tick(); c++;
      if (done != '0) begin
        order[k] = done[0] ? 0 : (done[1] ? 1 : 9);
        req = req & ~done;
        k++;
      end
    end
    req = '0;
    checks++; if (k != 2) begin failures++; $display("FAIL wrap_count: got %0d required 2", k); end
    if (k == 2) begin
      checks++; if (order[0] != 0 || order[1] != 1) begin failures++; $display("FAIL wrap_order: got %0d,%0d required 0,1", order[0], order[1]); end
    end
  endtask

  task automatic test_timeout;
    int n;
    set_req(3, 1'b0, 32'h80, 32'h0);
    prdata = 32'hFFFFFFFF; pready = 1'b0;
    tick();
    checks++; if ({psel, paddr} !== {1'b1, 32'h80}) begin failures++; $display("FAIL to_grant: got %b %h required 1 80", psel, paddr); end
    wait_done(40, n);
    checks++; if (n != 17) begin failures++; $display("FAIL to_latency: got %0d required 17", n); end
    checks++; if ({done, err, rdata} !== {4'b1000, 1'b1, 32'h0}) begin failures++; $display("FAIL to_abort: got %b %b %h required 1000 1 0", done, err, rdata); end
    checks++; if ({psel, penable} !== 2'b00) begin failures++; $display("FAIL to_bus: got %b required 00", {psel, penable}); end
    req = '0;
    tick();
    checks++; if ({done, err} !== 5'b0) begin failures++; $display("FAIL to_clear: got %b %b required 0000 0", done, err); end
    set_req(0, 1'b0, 32'h44, 32'h0);
    prdata = 32'hCAFEF00D; pready = 1'b1;
    wait_done(10, n);
    checks++; if (n != 3) begin failures++; $display("FAIL to_next_lat: got %0d required 3", n); end
    checks++; if ({done, err, rdata} !== {4'b0001, 1'b0, 32'hCAFEF00D}) begin failures++; $display("FAIL to_next: got %b %b %h required 0001 0 cafef00d", done, err, rdata); end
    req = '0;
  endtask

  task automatic test_slverr_reset;
    int n;
    int seen;
    set_req(1, 1'b1, 32'h20, 32'h11112222);
    pready = 1'b1; pslverr = 1'b1;
    wait_done(10, n);
    checks++; if ({done, err, rdata} !== {4'b0010, 1'b1, 32'h0}) begin failures++; $display("FAIL slverr: got %b %b %h required 0010 1 0", done, err, rdata); end
    req = '0; pslverr = 1'b0;
    tick();
    set_req(2, 1'b0, 32'h60, 32'h0);
    pready = 1'b0;
    tick(); tick(); tick();
    checks++; if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL rst_pre: got %b required 11", {psel, penable}); end
    hreset = 1'b1; req = '0;
    #1;
    checks++; if ({psel, penable} !== 2'b00) begin failures++; $display("FAIL rst_async: got %b required 00", {psel, penable}); end
    tick();
    hreset = 1'b0;
    pready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done != '0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rst_nodone: got %0d pulses required 0", seen); end
    set_req(0, 1'b0, 32'h500, 32'h0);
    set_req(3, 1'b0, 32'h50C, 32'h0);
    prdata = 32'h5555AAAA;
    wait_done(10, n);
    checks++; if (done !== 4'b0001) begin failures++; $display("FAIL rst_ptr: got %b required 0001", done); end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_round_robin();
    test_pointer_wrap();
    test_timeout();
    test_slverr_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
